reg_file_mp: RTL and testbench

//  Parametrised multi-port register file for the pipelined MIPS core; replaces the fixed 32x32 read mux.

---
 rtl/reg_file_mp_pkg.sv | 24 ++
 rtl/reg_read_port.sv | 71 +++++++
 rtl/reg_file_mp.sv | 79 +++++++
 tb/tb_reg_file_mp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and defaults for the multi-port MIPS register file.
// Read-source selection is centralised here so every read port decodes identically.
package reg_file_mp_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_BYPASS,
        SRC_MEM
    } rd_src_e;

    // Hardwired zero outranks the write bypass so r0 can never leak wdata.
    function automatic rd_src_e sel_src(input logic zero_hit, input logic fwd_hit);
        if (zero_hit)
            return SRC_ZERO;
        else if (fwd_hit)
            return SRC_BYPASS;
        else
            return SRC_MEM;
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One register-file read port: address decode, write bypass, zero register,
// pending lookup and optional output register.
module reg_read_port
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int READ_LAT = 0,
    parameter int WR_FWD   = 1,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 1 << ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            raddr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
    input  logic [DEPTH-1:0]             pend_i,
    input  logic                         we_i,
    input  logic [ADDR_W-1:0]            waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         rpend_o
);

    logic              zero_hit;
    logic              fwd_hit;
    rd_src_e           src;
    logic [DATA_W-1:0] val_d;
    logic              pend_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        zero_hit = (ZERO_REG != 0) && (raddr_i == '0);
        fwd_hit  = (WR_FWD != 0) && we_i && (waddr_i == raddr_i);
        src      = sel_src(zero_hit, fwd_hit);
        val_d    = mem_i[raddr_i];
        case (src)
            SRC_ZERO:   val_d = '0;
            SRC_BYPASS: val_d = wdata_i;
            SRC_MEM:    val_d = mem_i[raddr_i];
            default:    val_d = mem_i[raddr_i];
        endcase
        // A write landing this cycle retires the outstanding load it bypasses.
        pend_d = pend_i[raddr_i] & ~fwd_hit & ~zero_hit;
    end

    if (READ_LAT != 0) begin : g_reg
        logic [DATA_W-1:0] rdata_q;
        logic              rpend_q;

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
                rpend_q <= 1'b0;
            end else begin
                rdata_q <= val_d;
                rpend_q <= pend_d;
            end
        end

        assign rdata_o = rdata_q;
        assign rpend_o = rpend_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign rdata_o        = val_d;
        assign rpend_o        = pend_d;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with hardwired zero, write bypass and
// a per-register pending bit used by ID to stall on outstanding loads.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int N_READ   = 2,
    parameter int READ_LAT = 0,
    parameter int WR_FWD   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_READ*ADDR_W-1:0] raddr,
    output logic [N_READ*DATA_W-1:0] rdata,
    output logic [N_READ-1:0]        rpend,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             pend_q, pend_d;
    logic                         wr_ok;
    logic                         set_ok;

    assign wr_ok  = we && !((ZERO_REG != 0) && (waddr == '0));
    assign set_ok = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

    // The set is applied after the write so a new load on the same register wins.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_ok) begin
            mem_d[waddr]  = wdata;
            pend_d[waddr] = 1'b0;
        end
        if (set_ok)
            pend_d[pend_addr] = 1'b1;
    end

    // NOTE: the array must clear on reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < N_READ; i++) begin : g_rd
        reg_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .READ_LAT(READ_LAT),
            .WR_FWD  (WR_FWD),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .clk    (clk),
            .rst_n  (rst_n),
            .raddr_i(raddr[i*ADDR_W +: ADDR_W]),
            .mem_i  (mem_q),
            .pend_i (pend_q),
            .we_i   (we),
            .waddr_i(waddr),
            .wdata_i(wdata),
            .rdata_o(rdata[i*DATA_W +: DATA_W]),
            .rpend_o(rpend[i])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations share one write/pend stimulus stream,
// checked against directed vectors and a behavioural reference model.
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*AW-1:0] raddr;
    logic [3*AW-1:0] raddr3;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          pend_set;
    logic [AW-1:0] pend_addr;

    logic [2*DW-1:0] rdata_a, rdata_b;
    logic [1:0]      rpend_a, rpend_b;
    logic [3*DW-1:0] rdata_c;
    logic [2:0]      rpend_c;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // a: defaults (bypass, combinational); b: no bypass; c: registered, 3 ports
    reg_file_mp #(.N_READ(2), .READ_LAT(0), .WR_FWD(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_a), .rpend(rpend_a),
        .we(we), .waddr(waddr), .wdata(wdata), .pend_set(pend_set), .pend_addr(pend_addr));

    reg_file_mp #(.N_READ(2), .READ_LAT(0), .WR_FWD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_b), .rpend(rpend_b),
        .we(we), .waddr(waddr), .wdata(wdata), .pend_set(pend_set), .pend_addr(pend_addr));

    reg_file_mp #(.N_READ(3), .READ_LAT(1), .WR_FWD(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .raddr(raddr3), .rdata(rdata_c), .rpend(rpend_c),
        .we(we), .waddr(waddr), .wdata(wdata), .pend_set(pend_set), .pend_addr(pend_addr));

    // Reference model of architectural state plus the expected registered outputs of dut_c.
    logic [DW-1:0]   m_mem [DEPTH];
    logic [DEPTH-1:0] m_pend;
    logic [3*DW-1:0] exp_c_d;
    logic [2:0]      exp_c_p;

    function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a, input bit fwd);
        if (a == 0) return '0;
        if (fwd && we && waddr == a) return wdata;
        return m_mem[a];
    endfunction

    function automatic logic ref_pend(input logic [AW-1:0] a, input bit fwd);
        if (a == 0) return 1'b0;
        return m_pend[a] & ~(fwd && we && waddr == a);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            m_pend  <= '0;
            exp_c_d <= '0;
            exp_c_p <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_c_d[i*DW +: DW] <= ref_val(raddr3[i*AW +: AW], 1'b1);
                exp_c_p[i]          <= ref_pend(raddr3[i*AW +: AW], 1'b1);
            end
            if (we && waddr != 0) begin
                m_mem[waddr]  <= wdata;
                m_pend[waddr] <= 1'b0;
            end
            if (pend_set && pend_addr != 0) m_pend[pend_addr] <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input int cyc);
        logic [2*DW-1:0] ea_d, eb_d;
        logic [1:0]      ea_p, eb_p;
        for (int i = 0; i < 2; i++) begin
            ea_d[i*DW +: DW] = ref_val(raddr[i*AW +: AW], 1'b1);
            eb_d[i*DW +: DW] = ref_val(raddr[i*AW +: AW], 1'b0);
            ea_p[i]          = ref_pend(raddr[i*AW +: AW], 1'b1);
            eb_p[i]          = ref_pend(raddr[i*AW +: AW], 1'b0);
        end
        check($sformatf("rand%0d a.rdata", cyc), rdata_a, ea_d);
        check($sformatf("rand%0d a.rpend", cyc), rpend_a, ea_p);
        check($sformatf("rand%0d b.rdata", cyc), rdata_b, eb_d);
        check($sformatf("rand%0d b.rpend", cyc), rpend_b, eb_p);
        check($sformatf("rand%0d c.rdata", cyc), rdata_c, exp_c_d);
        check($sformatf("rand%0d c.rpend", cyc), rpend_c, exp_c_p);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          pset;
        logic [AW-1:0] paddr;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    p;
        logic [DW-1:0] nf_d0;
        logic          nf_p0;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic ps, input logic [AW-1:0] pa,
                                input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [1:0] ep,
                                input logic [DW-1:0] nd0, input logic np0);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd; v.pset = ps; v.paddr = pa;
        v.ra0 = r0; v.ra1 = r1; v.d0 = e0; v.d1 = e1; v.p = ep;
        v.nf_d0 = nd0; v.nf_p0 = np0;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        //             we wa   wdata          ps pa    r0    r1    d0            d1            p      nf_d0         nf_p0
        vecs[0]  = mk(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0,        0);
        vecs[1]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 32'h0,        0);
        vecs[2]  = mk(1, 5'd7, 32'h1234,      0, 5'd0, 5'd7, 5'd7, 32'h1234,     32'h1234,     2'b00, 32'h0,        0);
        vecs[3]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 5'd7, 5'd7, 32'h1234,     32'h1234,     2'b00, 32'h1234,     0);
        vecs[4]  = mk(0, 5'd0, 32'h0,         1, 5'd9, 5'd9, 5'd7, 32'h0,        32'h1234,     2'b00, 32'h0,        0);
        vecs[5]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 5'd9, 5'd9, 32'h0,        32'h0,        2'b11, 32'h0,        1);
        vecs[6]  = mk(1, 5'd9, 32'h55,        0, 5'd0, 5'd9, 5'd9, 32'h55,       32'h55,       2'b00, 32'h0,        1);
        vecs[7]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 5'd9, 5'd7, 32'h55,       32'h1234,     2'b00, 32'h55,       0);
        vecs[8]  = mk(1, 5'd3, 32'hAA,        1, 5'd3, 5'd3, 5'd3, 32'hAA,       32'hAA,       2'b00, 32'h0,        0);
        vecs[9]  = mk(0, 5'd0, 32'h0,         0, 5'd0, 5'd3, 5'd3, 32'hAA,       32'hAA,       2'b11, 32'hAA,       1);
        vecs[10] = mk(1, 5'd3, 32'hBB,        0, 5'd0, 5'd3, 5'd0, 32'hBB,       32'h0,        2'b00, 32'hAA,       1);
        vecs[11] = mk(0, 5'd0, 32'h0,         0, 5'd0, 5'd3, 5'd3, 32'hBB,       32'hBB,       2'b00, 32'hBB,       0);

        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        pend_set = 1'b0; pend_addr = '0; raddr = '0; raddr3 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset a.rdata", rdata_a, '0);
        check("reset a.rpend", rpend_a, '0);
        check("reset c.rdata", rdata_c, '0);
        check("reset c.rpend", rpend_c, '0);

        // Write r5, then a one-cycle reset that also carries a write and a pend set
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD;
        @(posedge clk); #1;
        we = 1'b0; raddr = {5'd5, 5'd5};
        #1 check("r5 before reset", rdata_a, {32'hDEAD, 32'hDEAD});
        rst_n = 1'b0; we = 1'b1; wdata = 32'hBEEF; pend_set = 1'b1; pend_addr = 5'd5;
        @(posedge clk); #1;
        rst_n = 1'b1; we = 1'b0; pend_set = 1'b0;
        #1;
        check("r5 after reset a.rdata", rdata_a, '0);
        check("r5 after reset a.rpend", rpend_a, '0);
        check("r5 after reset b.rdata", rdata_b, '0);

        for (int k = 0; k < 12; k++) begin
            we = vecs[k].we; waddr = vecs[k].waddr; wdata = vecs[k].wdata;
            pend_set = vecs[k].pset; pend_addr = vecs[k].paddr;
            raddr = {vecs[k].ra1, vecs[k].ra0};
            #1;
            check($sformatf("vec%0d a.rdata0", k), rdata_a[DW-1:0], vecs[k].d0);
            check($sformatf("vec%0d a.rdata1", k), rdata_a[2*DW-1:DW], vecs[k].d1);
            check($sformatf("vec%0d a.rpend", k), rpend_a, vecs[k].p);
            check($sformatf("vec%0d b.rdata0", k), rdata_b[DW-1:0], vecs[k].nf_d0);
            check($sformatf("vec%0d b.rpend0", k), rpend_b[0], vecs[k].nf_p0);
            @(posedge clk); #1;
        end
        we = 1'b0; pend_set = 1'b0;

        // Registered read: bypass captured at the write edge, one-cycle latency on new addresses
        we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE;
        raddr3 = {5'd0, 5'd12, 5'd12};
        @(posedge clk); #1;
        check("lat1 bypass capture", rdata_c, {32'h0, 32'hCAFE, 32'hCAFE});
        we = 1'b0; raddr3 = {5'd12, 5'd12, 5'd12};
        #1 check("lat1 holds until edge", rdata_c, {32'h0, 32'hCAFE, 32'hCAFE});
        @(posedge clk); #1;
        check("lat1 after edge", rdata_c, {32'hCAFE, 32'hCAFE, 32'hCAFE});

        for (int cyc = 0; cyc < 400; cyc++) begin
            we        = 1'($urandom_range(0, 1));
            waddr     = 5'($urandom_range(0, 7));
            wdata     = $urandom;
            pend_set  = ($urandom_range(0, 3) == 0);
            pend_addr = 5'($urandom_range(0, 7));
            raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            raddr3    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1 check_model(cyc);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
